grid_serializer: RTL and testbench
==================================

GRID_SERIALIZER -- requirements
Module: grid_serializer

Interface
REQ-001 SHALL take parameter ONE_BASED, default 1: 1 = digits emitted as 1..`GRID_LEN; 0 = digits emitted as 0..`GRID_LEN-1.
REQ-002 SHALL derive LEN=`GRID_LEN and AREA=`GRID_AREA from grid_dimensions.svh; DW=$clog2(`GRID_LEN+1); IW=$clog2(`GRID_LEN).
REQ-003 SHALL have one clock and a synchronous, active-high reset: clock, input, 1, rising-edge clock for all state.
REQ-004 reset, input, 1, synchronous active-high reset.
REQ-005 grid_done, input, 1, upstream grid finished (level).
REQ-006 grid_success, input, 1, upstream grid solved; qualified by grid_done.
REQ-007 grid_values, input, AREA*LEN, row-major one-hot tile values; tile (r,c) occupies bits [(r*LEN+c)*LEN +: LEN].
REQ-008 rq, input, 1, request to read out the solution (level, sampled each cycle).
REQ-009 rq_ack, output, 1, one-cycle pulse: request accepted, snapshot taken.
REQ-010 rq_nak, output, 1, one-cycle pulse: request refused.
REQ-011 out_valid / out_ready, output / input, 1 each, valid-ready beat handshake.
REQ-012 out_digit, output, DW, decoded digit of the current tile.
REQ-013 out_row / out_col, output, IW each, coordinates of the current tile.
REQ-014 out_last, output, 1, high with out_valid on tile (LEN-1,LEN-1).
REQ-015 busy, output, 1, high in SNAP and STREAM.
REQ-016 bad_tile, output, 1, sticky flag: a streamed tile was not one-hot (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, SNAP, STREAM.
REQ-018 IDLE: rq=1 & grid_done=1 & grid_success=1 -> SNAP, capture grid_values into an internal AREA*LEN register, and pulse rq_ack in the same cycle.
REQ-019 IDLE: rq=1 & (grid_done=0 | grid_success=0) -> pulse rq_nak, remain in IDLE; rq held high produces rq_nak every cycle.
REQ-020 SNAP: one cycle; clear the tile index to 0 and clear bad_tile -> STREAM; out_valid=0.
REQ-021 STREAM: out_valid=1; row/col/digit taken from the snapshot at the current index; the first beat is valid 2 cycles after the rq-accept edge.
REQ-022 A beat SHALL transfer when out_valid & out_ready; out_digit/out_row/out_col/out_last SHALL be stable while out_valid & !out_ready.
REQ-023 Index SHALL advance row-major (col increments, wraps to 0 at LEN-1 with row+1); exactly AREA beats per request.
REQ-024 A transfer with out_last=1 -> IDLE next cycle; out_valid=0 in that cycle.
REQ-025 rq during SNAP/STREAM SHALL be ignored, with no ack/nak; upstream changes after the snapshot SHALL NOT affect streamed data.
REQ-026 Decode: a one-hot bit k SHALL give out_digit = k+ONE_BASED.
REQ-027 At most one of rq_ack/rq_nak SHALL be high in any cycle.

Reset
REQ-028 reset=1 SHALL force IDLE on the next edge with out_valid=0, rq_ack=0, rq_nak=0, busy=0, bad_tile=0, and index=0; outputs SHALL be 0 while reset is held.
REQ-029 Reset mid-STREAM SHALL abort the stream; no further beats are emitted and no out_last is issued; the snapshot register need not be cleared.

Configuration
REQ-030 With macro GRID_SERIALIZER_ONEHOT_CHECK_EN defined, a streamed tile whose value is zero or multi-hot SHALL set bad_tile on its transfer cycle (sticky until the next SNAP or reset) and drive out_digit=0.
REQ-031 Without GRID_SERIALIZER_ONEHOT_CHECK_EN, bad_tile SHALL be tied 0, and out_digit SHALL encode the lowest set bit (all-zero gives digit ONE_BASED+0 equivalent to bit 0).

Verification (GRID_ORD=3, LEN=9, ONE_BASED=1)
REQ-032 Solved grid, rq pulse, out_ready=1 -> rq_ack, 81 beats on consecutive cycles, first beat (0,0), out_last only on beat 81 at (8,8), then IDLE.
REQ-033 grid_done=1, grid_success=0, rq=1 for 3 cycles -> 3 rq_nak pulses, busy=0, out_valid never high.
REQ-034 out_ready toggles 1,0,0,1 on a tile with value 9'b000010000 -> out_digit=5 held stable across the stall; index advances only on ready cycles.
REQ-035 Snapshot taken, grid_values then forced to all-zero -> all 81 digits still match the snapshot.
REQ-036 Reset asserted at beat 40 -> out_valid=0 next edge, IDLE; a new rq restarts the stream at (0,0).
REQ-037 With CHECK_EN, tile (2,3)=9'b000000011 -> bad_tile rises on beat 22 with out_digit=0 and stays high; without CHECK_EN -> out_digit=1 and bad_tile=0.

Source files
------------

// File: rtl/grid_serializer_if.sv
// Valid/ready beat stream carrying one decoded tile per transfer.
interface grid_serializer_if #(
  parameter int DW = 4,
  parameter int IW = 4
);
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_digit;
  logic [IW-1:0] out_row;
  logic [IW-1:0] out_col;
  logic          out_last;

  modport master (
    output out_valid, out_digit, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_digit, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/grid_dimensions.svh
// Grid geometry shared by the serializer and its neighbours.
// GRID_ORD may be overridden on the command line; LEN and AREA follow from it.
`ifndef GRID_DIMENSIONS_SVH
`define GRID_DIMENSIONS_SVH
`ifndef GRID_ORD
`define GRID_ORD 3
`endif
`define GRID_LEN (`GRID_ORD * `GRID_ORD)
`define GRID_AREA (`GRID_LEN * `GRID_LEN)
`endif

// File: rtl/grid_serializer.sv
// Snapshots a solved one-hot grid on request and streams it out tile by tile, row-major.
// Optional macro GRID_SERIALIZER_ONEHOT_CHECK_EN flags non-one-hot tiles via bad_tile.
`include "grid_dimensions.svh"

module grid_serializer #(
  parameter int ONE_BASED = 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              grid_done,
  input  logic                              grid_success,
  input  logic [`GRID_AREA*`GRID_LEN-1:0]   grid_values,
  input  logic                              rq,
  output logic                              rq_ack,
  output logic                              rq_nak,
  output logic                              busy,
  output logic                              bad_tile,
  grid_serializer_if.master                 out_if
);

  localparam int LEN  = `GRID_LEN;
  localparam int AREA = `GRID_AREA;
  localparam int DW   = $clog2(LEN + 1);
  localparam int IW   = $clog2(LEN);
  localparam int AW   = $clog2(AREA);
  localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SNAP   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IW-1:0]  row_q, row_d;
  logic [IW-1:0]  col_q, col_d;
  logic           ack_q, ack_d;
  logic           nak_q, nak_d;
  logic [LEN-1:0] snap_q [AREA];
  logic [LEN-1:0] snap_d [AREA];
  logic [LEN-1:0] grid_tiles [AREA];
  logic [AW-1:0]  tile_idx;
  logic [LEN-1:0] cur_tile;
  logic           streaming;
  logic           at_last;

  function automatic logic [DW-1:0] decode_lowest(input logic [LEN-1:0] t);
    logic [DW-1:0] d;
    d = DW'(ONE_BASED);
    for (int k = LEN - 1; k >= 0; k--) begin
      if (t[k]) d = DW'(k + ONE_BASED);
    end
    return d;
  endfunction

`ifdef GRID_SERIALIZER_ONEHOT_CHECK_EN
  logic bad_q, bad_d;

  function automatic logic is_onehot(input logic [LEN-1:0] t);
    return (t != '0) && ((t & (t - LEN'(1))) == '0);
  endfunction
`endif

  genvar g;
  generate
    for (g = 0; g < AREA; g++) begin : g_unpack
      assign grid_tiles[g] = grid_values[g*LEN +: LEN];
    end
  endgenerate

  assign tile_idx  = AW'(row_q) * AW'(LEN) + AW'(col_q);
  assign cur_tile  = snap_q[tile_idx];
  assign streaming = (state_q == ST_STREAM);
  assign at_last   = (row_q == LAST_IDX) && (col_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    ack_d   = 1'b0;
    nak_d   = 1'b0;
    snap_d  = snap_q;
`ifdef GRID_SERIALIZER_ONEHOT_CHECK_EN
    bad_d   = bad_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rq) begin
          if (grid_done && grid_success) begin
            state_d = ST_SNAP;
            ack_d   = 1'b1;
            snap_d  = grid_tiles;
          end else begin
            nak_d = 1'b1;
          end
        end
      end
      ST_SNAP: begin
        row_d   = '0;
        col_d   = '0;
        state_d = ST_STREAM;
`ifdef GRID_SERIALIZER_ONEHOT_CHECK_EN
        bad_d   = 1'b0;
`endif
      end
      ST_STREAM: begin
        if (out_if.out_ready) begin
`ifdef GRID_SERIALIZER_ONEHOT_CHECK_EN
          bad_d = bad_q | ~is_onehot(cur_tile);
`endif
          // Row-major walk; the index wraps to (0,0) after the final tile.
          if (col_q == LAST_IDX) begin
            col_d = '0;
            row_d = (row_q == LAST_IDX) ? '0 : row_q + IW'(1);
          end else begin
            col_d = col_q + IW'(1);
          end
          if (at_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      ack_q   <= 1'b0;
      nak_q   <= 1'b0;
`ifdef GRID_SERIALIZER_ONEHOT_CHECK_EN
      bad_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ack_q   <= ack_d;
      nak_q   <= nak_d;
`ifdef GRID_SERIALIZER_ONEHOT_CHECK_EN
      bad_q   <= bad_d;
`endif
    end
  end

  // Snapshot is pure data and survives reset; it is only reloaded on an accepted request.
  always_ff @(posedge clock) begin
    snap_q <= snap_d;
  end

  assign rq_ack           = ack_q;
  assign rq_nak           = nak_q;
  assign busy             = (state_q != ST_IDLE);
  assign out_if.out_valid = streaming;
  assign out_if.out_row   = row_q;
  assign out_if.out_col   = col_q;
  assign out_if.out_last  = streaming && at_last;

`ifdef GRID_SERIALIZER_ONEHOT_CHECK_EN
  assign bad_tile         = bad_q;
  assign out_if.out_digit = (streaming && is_onehot(cur_tile)) ? decode_lowest(cur_tile) : '0;
`else
  assign bad_tile         = 1'b0;
  assign out_if.out_digit = streaming ? decode_lowest(cur_tile) : '0;
`endif

endmodule

// File: tb/tb_grid_serializer.sv
// Self-checking bench for grid_serializer (GRID_ORD=3, ONE_BASED=1): request table,
// hand-written corner sequences and randomized grids against a reference model.
module tb_grid_serializer;
  localparam int LEN  = 9;
  localparam int AREA = 81;
  localparam int DW   = 4;
  localparam int IW   = 4;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  grid_done;
  logic                  grid_success;
  logic [AREA*LEN-1:0]   grid_values;
  logic                  rq;
  logic                  rq_ack;
  logic                  rq_nak;
  logic                  busy;
  logic                  bad_tile;

  grid_serializer_if #(.DW(DW), .IW(IW)) sif ();

  grid_serializer #(.ONE_BASED(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .grid_done    (grid_done),
    .grid_success (grid_success),
    .grid_values  (grid_values),
    .rq           (rq),
    .rq_ack       (rq_ack),
    .rq_nak       (rq_nak),
    .busy         (busy),
    .bad_tile     (bad_tile),
    .out_if       (sif)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  logic [LEN-1:0] snap_model [AREA];

  typedef struct {
    logic done;
    logic success;
    logic req;
    logic exp_ack;
    logic exp_nak;
  } req_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference decode: position of the lowest set bit, counted from 1.
  function automatic int model_digit(input logic [LEN-1:0] t);
`ifdef GRID_SERIALIZER_ONEHOT_CHECK_EN
    if ($countones(t) != 1) return 0;
`endif
    for (int k = 0; k < LEN; k++) begin
      if (t[k]) return k + 1;
    end
    return 1;
  endfunction

  function automatic logic model_bad(input logic [LEN-1:0] t);
`ifdef GRID_SERIALIZER_ONEHOT_CHECK_EN
    return $countones(t) != 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_tile(input int t, input logic [LEN-1:0] v);
    grid_values[t*LEN +: LEN] = v;
  endtask

  task automatic fill_grid(input bit dirty);
    logic [LEN-1:0] one;
    one = 1;
    for (int t = 0; t < AREA; t++) begin
      if (dirty && $urandom_range(0, 3) == 0) set_tile(t, LEN'($urandom));
      else set_tile(t, one << $urandom_range(0, LEN - 1));
    end
  endtask

  task automatic capture_model();
    for (int t = 0; t < AREA; t++) snap_model[t] = grid_values[t*LEN +: LEN];
  endtask

  task automatic request_accept();
    grid_done    = 1'b1;
    grid_success = 1'b1;
    rq           = 1'b1;
    capture_model();
    step();
    check("accept_ack", rq_ack, 1);
    check("accept_nak", rq_nak, 0);
    check("snap_busy", busy, 1);
    check("snap_valid", sif.out_valid, 0);
    rq = 1'b0;
    step();
    check("first_beat_valid", sif.out_valid, 1);
  endtask

  // Walks beats [start, stop) against the model, optionally with random stalls and upstream noise.
  task automatic drain(input int start, input bit rand_ready, input int stop, input bit noise);
    int   beat;
    int   cycles;
    logic bad_exp;
    logic ready;
    beat    = start;
    cycles  = 0;
    bad_exp = 1'b0;
    for (int b = 0; b < start; b++) bad_exp = bad_exp | model_bad(snap_model[b]);
    while (beat < stop && cycles < 1000) begin
      check("beat_valid", sif.out_valid, 1);
      check("beat_row", sif.out_row, beat / LEN);
      check("beat_col", sif.out_col, beat % LEN);
      check("beat_digit", sif.out_digit, model_digit(snap_model[beat]));
      check("beat_last", sif.out_last, beat == AREA - 1);
      check("beat_bad", bad_tile, bad_exp);
      check("beat_no_ack", rq_ack, 0);
      check("beat_no_nak", rq_nak, 0);
      ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      sif.out_ready = ready;
      if (noise) begin
        rq           = 1'($urandom_range(0, 1));
        grid_done    = 1'($urandom_range(0, 1));
        grid_success = 1'($urandom_range(0, 1));
      end
      if (ready && beat == AREA - 1) rq = 1'b0;
      step();
      cycles++;
      if (ready) begin
        bad_exp = bad_exp | model_bad(snap_model[beat]);
        beat++;
      end
    end
    rq = 1'b0;
    if (cycles >= 1000) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: reached beat %0d, required %0d", beat, stop);
    end
    if (!rand_ready) check("consecutive_cycles", cycles, stop - start);
    if (stop == AREA) begin
      check("end_valid", sif.out_valid, 0);
      check("end_busy", busy, 0);
      check("end_ack", rq_ack, 0);
      check("end_nak", rq_nak, 0);
      check("end_bad_sticky", bad_tile, bad_exp);
    end
  endtask

  req_vec_t tbl [6];

  initial begin
    tbl[0] = '{done: 1'b0, success: 1'b0, req: 1'b1, exp_ack: 1'b0, exp_nak: 1'b1};
    tbl[1] = '{done: 1'b0, success: 1'b1, req: 1'b1, exp_ack: 1'b0, exp_nak: 1'b1};
    tbl[2] = '{done: 1'b1, success: 1'b0, req: 1'b1, exp_ack: 1'b0, exp_nak: 1'b1};
    tbl[3] = '{done: 1'b1, success: 1'b1, req: 1'b0, exp_ack: 1'b0, exp_nak: 1'b0};
    tbl[4] = '{done: 1'b1, success: 1'b1, req: 1'b1, exp_ack: 1'b1, exp_nak: 1'b0};
    tbl[5] = '{done: 1'b0, success: 1'b1, req: 1'b0, exp_ack: 1'b0, exp_nak: 1'b0};

    reset         = 1'b1;
    rq            = 1'b0;
    grid_done     = 1'b0;
    grid_success  = 1'b0;
    grid_values   = '0;
    sif.out_ready = 1'b0;
    repeat (3) step();
    check("rst_valid", sif.out_valid, 0);
    check("rst_ack", rq_ack, 0);
    check("rst_nak", rq_nak, 0);
    check("rst_busy", busy, 0);
    check("rst_bad", bad_tile, 0);
    check("rst_last", sif.out_last, 0);
    rq = 1'b1; grid_done = 1'b1; grid_success = 1'b1;
    step();
    check("rst_held_ack", rq_ack, 0);
    check("rst_held_busy", busy, 0);
    rq = 1'b0;
    reset = 1'b0;
    step();

    // Request table: done/success combinations; accepted requests are streamed out fully.
    for (int i = 0; i < 6; i++) begin
      fill_grid(1'b0);
      grid_done    = tbl[i].done;
      grid_success = tbl[i].success;
      rq           = tbl[i].req;
      capture_model();
      step();
      check("tbl_ack", rq_ack, tbl[i].exp_ack);
      check("tbl_nak", rq_nak, tbl[i].exp_nak);
      check("tbl_busy", busy, tbl[i].exp_ack);
      check("tbl_valid", sif.out_valid, 0);
      rq = 1'b0;
      step();
      if (tbl[i].exp_ack) begin
        check("tbl_first_valid", sif.out_valid, 1);
        drain(0, 1'b0, AREA, 1'b0);
      end else begin
        check("tbl_idle_valid", sif.out_valid, 0);
      end
    end

    // Held request on an unsolved grid: one nak per cycle, never streaming.
    grid_done = 1'b1; grid_success = 1'b0; rq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("nak_pulse", rq_nak, 1);
      check("nak_no_ack", rq_ack, 0);
      check("nak_busy", busy, 0);
      check("nak_valid", sif.out_valid, 0);
    end
    rq = 1'b0;
    step();
    check("nak_release", rq_nak, 0);

    // Stall on tile (0,1) = bit 4: ready 1,0,0,1 keeps digit 5 stable.
    fill_grid(1'b0);
    set_tile(1, 9'b000010000);
    request_accept();
    drain(0, 1'b0, 1, 1'b0);
    sif.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_digit", sif.out_digit, 5);
      check("stall_col", sif.out_col, 1);
      check("stall_valid", sif.out_valid, 1);
    end
    drain(1, 1'b0, AREA, 1'b0);

    // Upstream cleared and noisy after the snapshot: data still comes from the snapshot.
    fill_grid(1'b0);
    request_accept();
    grid_values = '0;
    drain(0, 1'b1, AREA, 1'b1);

    // Multi-hot tile (2,3) = 9'b000000011, i.e. beat 22.
    fill_grid(1'b0);
    set_tile(2 * LEN + 3, 9'b000000011);
    request_accept();
    drain(0, 1'b1, AREA, 1'b1);

    // Randomized grids, some tiles not one-hot.
    for (int n = 0; n < 3; n++) begin
      fill_grid(1'b1);
      request_accept();
      if ($urandom_range(0, 1) == 1) grid_values = '0;
      drain(0, 1'b1, AREA, 1'b1);
    end

    // Reset at beat 40 aborts the stream; a new request restarts at (0,0).
    fill_grid(1'b1);
    request_accept();
    drain(0, 1'b0, 40, 1'b0);
    reset = 1'b1;
    step();
    check("abort_valid", sif.out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_last", sif.out_last, 0);
    check("abort_bad", bad_tile, 0);
    check("abort_ack", rq_ack, 0);
    reset = 1'b0;
    step();
    check("abort_stays_idle", sif.out_valid, 0);
    fill_grid(1'b0);
    request_accept();
    check("restart_row", sif.out_row, 0);
    check("restart_col", sif.out_col, 0);
    drain(0, 1'b1, AREA, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
